mmio_timer: RTL and testbench

Memory-mapped timebase and countdown-timer peripheral for the CPU data bus. It runs from a single system clock and replaces the per-frequency clock generators and ad-hoc second/millisecond/microsecond counters. It provides free-running µs/ms/s counters plus NCH independent countdown channels with auto-reload, sticky expiry flags and per-channel interrupt outputs. The top-level address decoder drives `sel` when the high address field selects the timer region.

---
 rtl/mmio_timer.sv | 173 +++++++++++++++++
 tb/tb_mmio_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped timebase (us/ms/s free-running counters) plus NCH countdown
// channels with auto-reload, sticky expiry flags and per-channel interrupts.
module mmio_timer #(
    parameter int unsigned CLK_HZ = 1000000,
    parameter int unsigned NCH    = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           sel,
    input  logic           we,
    input  logic [7:0]     addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] irq
);

    localparam int unsigned PreDiv = CLK_HZ / 1000000;

    logic [31:0] pre_q, pre_d;
    logic [9:0]  us_sub_q, us_sub_d;
    logic [9:0]  ms_sub_q, ms_sub_d;
    logic [31:0] cnt_us_q, cnt_us_d;
    logic [31:0] cnt_ms_q, cnt_ms_d;
    logic [31:0] cnt_s_q, cnt_s_d;
    logic        us_tick, ms_tick, s_tick, gclr;

    logic [31:0] load_q  [NCH];
    logic [31:0] load_d  [NCH];
    logic [31:0] count_q [NCH];
    logic [31:0] count_d [NCH];
    logic [3:0]  ctrl_q  [NCH];
    logic [3:0]  ctrl_d  [NCH];
    logic [NCH-1:0] exp_q, exp_d;

    logic [NCH-1:0] ld_we, ct_we, st_we, ctick, dec, expire;

    logic       wr;
    logic [3:0] page;
    logic [1:0] word;
    logic [3:0] ch_idx;
    logic       ch_hit;
    logic [1:0] unused_addr;

    assign wr          = sel && we;
    assign page        = addr[7:4];
    assign word        = addr[3:2];
    assign ch_idx      = page - 4'd4;
    assign ch_hit      = (page >= 4'd4) && ({28'd0, ch_idx} < NCH);
    assign unused_addr = addr[1:0];

    // Free-running timebase; a GCTRL clear overrides any increment this cycle.
    always_comb begin
        us_tick  = (pre_q == PreDiv - 1);
        ms_tick  = us_tick && (us_sub_q == 10'd999);
        s_tick   = ms_tick && (ms_sub_q == 10'd999);
        gclr     = wr && (addr[7:2] == 6'h03) && wdata[0];
        pre_d    = pre_q;
        us_sub_d = us_sub_q;
        ms_sub_d = ms_sub_q;
        cnt_us_d = cnt_us_q;
        cnt_ms_d = cnt_ms_q;
        cnt_s_d  = cnt_s_q;
        if (gclr) begin
            pre_d    = '0;
            us_sub_d = '0;
            ms_sub_d = '0;
            cnt_us_d = '0;
            cnt_ms_d = '0;
            cnt_s_d  = '0;
        end else begin
            pre_d = us_tick ? 32'd0 : pre_q + 32'd1;
            if (us_tick) begin
                us_sub_d = ms_tick ? 10'd0 : us_sub_q + 10'd1;
                cnt_us_d = cnt_us_q + 32'd1;
            end
            if (ms_tick) begin
                ms_sub_d = s_tick ? 10'd0 : ms_sub_q + 10'd1;
                cnt_ms_d = cnt_ms_q + 32'd1;
            end
            if (s_tick) begin
                cnt_s_d = cnt_s_q + 32'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ld_we[k]  = wr && ch_hit && (ch_idx == 4'(k)) && (word == 2'd0);
            ct_we[k]  = wr && ch_hit && (ch_idx == 4'(k)) && (word == 2'd2);
            st_we[k]  = wr && ch_hit && (ch_idx == 4'(k)) && (word == 2'd3);
            ctick[k]  = ctrl_q[k][2] ? ms_tick : us_tick;
            // CPU writes to LOAD/CTRL take priority over this cycle's decrement.
            dec[k]    = ctrl_q[k][0] && ctick[k] && (count_q[k] != 32'd0)
                        && !ld_we[k] && !ct_we[k];
            expire[k] = dec[k] && (count_q[k] == 32'd1);

            load_d[k]  = load_q[k];
            count_d[k] = count_q[k];
            ctrl_d[k]  = ctrl_q[k];
            if (ld_we[k]) begin
                load_d[k]  = wdata;
                count_d[k] = wdata;
            end else if (dec[k]) begin
                if (expire[k]) begin
                    count_d[k] = ctrl_q[k][1] ? load_q[k] : 32'd0;
                end else begin
                    count_d[k] = count_q[k] - 32'd1;
                end
            end
            if (ct_we[k]) begin
                ctrl_d[k] = wdata[3:0];
            end else if (expire[k] && !ctrl_q[k][1]) begin
                ctrl_d[k] = ctrl_q[k] & 4'b1110;
            end
            exp_d[k] = (exp_q[k] && !(st_we[k] && wdata[0])) || expire[k];
            irq[k]   = exp_q[k] && ctrl_q[k][3];
        end
    end

    always_comb begin
        rdata = '0;
        if (page == 4'd0) begin
            case (word)
                2'd0:    rdata = cnt_us_q;
                2'd1:    rdata = cnt_ms_q;
                2'd2:    rdata = cnt_s_q;
                default: rdata = '0;
            endcase
        end else if (ch_hit) begin
            for (int k = 0; k < NCH; k++) begin
                if (ch_idx == 4'(k)) begin
                    case (word)
                        2'd0:    rdata = load_q[k];
                        2'd1:    rdata = count_q[k];
                        2'd2:    rdata = {28'd0, ctrl_q[k]};
                        default: rdata = {31'd0, exp_q[k]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q    <= '0;
            us_sub_q <= '0;
            ms_sub_q <= '0;
            cnt_us_q <= '0;
            cnt_ms_q <= '0;
            cnt_s_q  <= '0;
            exp_q    <= '0;
            for (int k = 0; k < NCH; k++) begin
                load_q[k]  <= '0;
                count_q[k] <= '0;
                ctrl_q[k]  <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            us_sub_q <= us_sub_d;
            ms_sub_q <= ms_sub_d;
            cnt_us_q <= cnt_us_d;
            cnt_ms_q <= cnt_ms_d;
            cnt_s_q  <= cnt_s_d;
            exp_q    <= exp_d;
            for (int k = 0; k < NCH; k++) begin
                load_q[k]  <= load_d[k];
                count_q[k] <= count_d[k];
                ctrl_q[k]  <= ctrl_d[k];
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register-map vectors, hand-timed corner
// sequences and randomized channel runs against an arithmetic reference model.
module tb_mmio_timer;

    logic        clock = 1'b0;
    logic        reset, sel, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata, rdata4;
    logic [3:0]  irq;
    logic [1:0]  irq4;

    always #5 clock = ~clock;

    mmio_timer #(.CLK_HZ(1000000), .NCH(4)) dut (
        .clock (clock), .reset (reset), .sel (sel), .we (we),
        .addr  (addr),  .wdata (wdata), .rdata (rdata), .irq (irq)
    );

    mmio_timer #(.CLK_HZ(4000000), .NCH(2)) dut4 (
        .clock (clock), .reset (reset), .sel (sel), .we (we),
        .addr  (addr),  .wdata (wdata), .rdata (rdata4), .irq (irq4)
    );

    int checks = 0;
    int failures = 0;
    longint unsigned us_model = 0;

    // Microseconds elapsed since the last reset or GCTRL clear (1 MHz instance).
    always @(posedge clock) begin
        if (reset || (sel && we && addr[7:2] == 6'h03 && wdata[0])) us_model <= 0;
        else us_model <= us_model + 1;
    end

    typedef struct {
        logic        do_wr;
        logic [7:0]  waddr;
        logic [31:0] wdat;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  base;
        logic [31:0] w, exp_cnt, exp_ctrl;
        int unsigned k, ld, n;
        logic        ar, ie, exp_exp, exp_en, seen;

        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick();
        reset = 1'b0;

        // Reset state
        do_reset();
        check("rst_irq", {28'd0, irq}, 32'd0);
        chk_rd("rst_cnt_us", 8'h00, 32'd0);
        chk_rd("rst_load0", 8'h40, 32'd0);

        // 4 MHz prescaler and GCTRL clear coinciding with a us_tick
        do_reset();
        repeat (8) tick();
        addr = 8'h00; #1;
        check("p4_cnt_us_8cyc", rdata4, 32'd2);
        repeat (3) tick();
        check("p4_cnt_us_11cyc", rdata4, 32'd2);
        wr(8'h0C, 32'd1);
        addr = 8'h00; #1; check("p4_clr_us", rdata4, 32'd0);
        addr = 8'h04; #1; check("p4_clr_ms", rdata4, 32'd0);
        addr = 8'h08; #1; check("p4_clr_s", rdata4, 32'd0);
        chk_rd("clr_us_1m", 8'h00, 32'd0);

        // Timebase at 1 MHz
        do_reset();
        repeat (2500) tick();
        chk_rd("tb_cnt_us", 8'h00, 32'd2500);
        chk_rd("tb_cnt_ms", 8'h04, 32'd2);
        chk_rd("tb_cnt_s", 8'h08, 32'd0);
        chk_rd("tb_gctrl_rd", 8'h0C, 32'd0);

        // Register-map vectors
        do_reset();
        vecs[0]  = '{1'b1, 8'h40, 32'h12345678, 8'h40, 32'h12345678};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        8'h44, 32'h12345678};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,        8'h43, 32'h12345678};
        vecs[3]  = '{1'b1, 8'h48, 32'hFFFFFFF6, 8'h48, 32'h00000006};
        vecs[4]  = '{1'b1, 8'h80, 32'hDEADBEEF, 8'h80, 32'h0};
        vecs[5]  = '{1'b0, 8'h00, 32'h0,        8'h40, 32'h12345678};
        vecs[6]  = '{1'b1, 8'h74, 32'h00000055, 8'h74, 32'h0};
        vecs[7]  = '{1'b1, 8'h7C, 32'h00000001, 8'h7C, 32'h0};
        vecs[8]  = '{1'b1, 8'h78, 32'h000000F0, 8'h78, 32'h0};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,        8'h20, 32'h0};
        vecs[10] = '{1'b1, 8'hC0, 32'h00000001, 8'hF0, 32'h0};
        vecs[11] = '{1'b1, 8'h50, 32'h00000007, 8'h54, 32'h00000007};
        vecs[12] = '{1'b1, 8'h60, 32'h000000A5, 8'h60, 32'h000000A5};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdat);
            chk_rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        addr = 8'h60; #1;
        check("nch2_unmapped", rdata4, 32'd0);

        // One-shot countdown on channel 0
        do_reset();
        wr(8'h40, 32'd3);
        wr(8'h48, 32'h9);
        chk_rd("os_cnt_start", 8'h44, 32'd3);
        tick(); chk_rd("os_cnt2", 8'h44, 32'd2);
        tick(); chk_rd("os_cnt1", 8'h44, 32'd1);
        check("os_irq_before", {31'd0, irq[0]}, 32'd0);
        tick(); chk_rd("os_cnt0", 8'h44, 32'd0);
        chk_rd("os_expired", 8'h4C, 32'd1);
        check("os_irq_set", {31'd0, irq[0]}, 32'd1);
        chk_rd("os_en_clr", 8'h48, 32'h8);
        tick(); chk_rd("os_cnt_hold", 8'h44, 32'd0);
        wr(8'h4C, 32'd1);
        check("os_irq_w1c", {31'd0, irq[0]}, 32'd0);
        chk_rd("os_status_w1c", 8'h4C, 32'd0);

        // Auto-reload on channel 1, W1C colliding with an expiry
        do_reset();
        wr(8'h50, 32'd2);
        wr(8'h58, 32'hB);
        tick(); chk_rd("ar_cnt_a", 8'h54, 32'd1);
        chk_rd("ar_stat_a", 8'h5C, 32'd0);
        tick(); chk_rd("ar_cnt_b", 8'h54, 32'd2);
        chk_rd("ar_stat_b", 8'h5C, 32'd1);
        check("ar_irq", {31'd0, irq[1]}, 32'd1);
        tick(); chk_rd("ar_cnt_c", 8'h54, 32'd1);
        wr(8'h5C, 32'd1);
        chk_rd("ar_cnt_d", 8'h54, 32'd2);
        chk_rd("ar_set_wins", 8'h5C, 32'd1);
        wr(8'h5C, 32'd1);
        chk_rd("ar_w1c_clear", 8'h5C, 32'd0);

        // ms-tick channel 2: expires at edge 5000, not at 4999
        do_reset();
        wr(8'h60, 32'd5);
        wr(8'h68, 32'hD);
        repeat (4997) tick();
        chk_rd("ms_cnt_4999", 8'h64, 32'd1);
        chk_rd("ms_stat_4999", 8'h6C, 32'd0);
        check("ms_irq_4999", {31'd0, irq[2]}, 32'd0);
        tick();
        chk_rd("ms_stat_5000", 8'h6C, 32'd1);
        check("ms_irq_5000", {31'd0, irq[2]}, 32'd1);
        chk_rd("ms_ctrl_5000", 8'h68, 32'hC);
        chk_rd("ms_cnt_ms", 8'h04, 32'd5);
        // LOAD = 0 stays inert
        wr(8'h6C, 32'd1);
        wr(8'h60, 32'd0);
        wr(8'h68, 32'hD);
        seen = 1'b0;
        repeat (10000) begin
            tick();
            if (irq[2]) seen = 1'b1;
        end
        check("load0_no_irq", {31'd0, seen}, 32'd0);
        chk_rd("load0_stat", 8'h6C, 32'd0);
        chk_rd("load0_en", 8'h68, 32'hD);

        // Randomized channel runs against the arithmetic model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            k    = $urandom_range(0, 3);
            ld   = $urandom_range(1, 20);
            ar   = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            n    = $urandom_range(0, 45);
            base = 8'h40 + 8'(16 * k);
            wr(base + 8'h08, 32'd0);
            wr(base + 8'h0C, 32'd1);
            wr(base, ld);
            w = $urandom;
            w[3:0] = {ie, 1'b0, ar, 1'b1};
            wr(base + 8'h08, w);
            repeat (n) tick();
            exp_exp = (n >= ld);
            if (ar) begin
                exp_cnt = ld - (n % ld);
                exp_en  = 1'b1;
            end else begin
                exp_cnt = (n >= ld) ? 32'd0 : ld - n;
                exp_en  = (n < ld);
            end
            exp_ctrl = {28'd0, ie, 1'b0, ar, exp_en};
            chk_rd($sformatf("rnd%0d_count", it), base + 8'h04, exp_cnt);
            chk_rd($sformatf("rnd%0d_status", it), base + 8'h0C, {31'd0, exp_exp});
            chk_rd($sformatf("rnd%0d_ctrl", it), base + 8'h08, exp_ctrl);
            check($sformatf("rnd%0d_irq", it), {31'd0, irq[k[1:0]]}, {31'd0, exp_exp && ie});
            chk_rd($sformatf("rnd%0d_us", it), 8'h00, us_model[31:0]);
            chk_rd($sformatf("rnd%0d_ms", it), 8'h04, 32'(us_model / 1000));
        end

        // Reset during active countdowns
        do_reset();
        wr(8'h40, 32'd100);
        wr(8'h48, 32'hB);
        wr(8'h50, 32'd1);
        wr(8'h58, 32'hB);
        repeat (5) tick();
        check("mid_irq_pre", {31'd0, irq[1]}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_irq", {28'd0, irq}, 32'd0);
        check("mid_irq4", {30'd0, irq4}, 32'd0);
        for (int a = 0; a < 256; a += 16) begin
            for (int j = 0; j < 16; j += 4) begin
                chk_rd($sformatf("mid_rd_%02h", a + j), 8'(a + j), 32'd0);
            end
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
